// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding, frame constants and address helper for boot_loader
package boot_pkg;

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} boot_state_t;

  localparam logic [7:0] BOOT_MAGIC = 8'hB0;

  function automatic logic [31:0] word_to_addr(input logic [31:0] index);
    return {index[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - 4-byte little-endian word assembler shared by the LEN and DATA phases
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;

  // word is the value including the byte being accepted, so the 4th byte is usable in its own cycle
  assign word       = {in_data, shreg[31:8]};
  assign word_valid = in_valid && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (in_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream image loader into IMEM; optional inter-byte timeout under BOOT_LOADER_TIMEOUT_EN
module boot_loader
  import boot_pkg::*;
#(
  parameter int          IMEM_DEPTH     = 1024,
  parameter logic [7:0]  MAGIC          = BOOT_MAGIC,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int                IDX_W   = $clog2(IMEM_DEPTH + 1);
  localparam logic [31:0]       DEPTH_W = 32'(IMEM_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);

  boot_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      len;
  logic [7:0]       xor_acc;
  logic             acc;
  logic             asm_valid;
  logic             asm_clr;
  logic [31:0]      word;
  logic             word_valid;
  logic             timeout_hit;

  assign acc       = rx_valid && rx_ready;
  assign asm_valid = acc && ((state == LEN) || (state == DATA));
  assign asm_clr   = acc && (rx_data == MAGIC) &&
                     ((state == IDLE) || (state == DONE) || (state == ERR));

  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign core_rst = (state != DONE);

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .in_valid   (asm_valid),
    .in_data    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef BOOT_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             counting;

  assign counting    = (state == LEN) || (state == DATA) || (state == CSUM);
  assign timeout_hit = counting && !acc && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || acc || !counting) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      idx        <= '0;
      len        <= 32'd0;
      xor_acc    <= 8'd0;
    end else begin
      rx_ready <= 1'b1;
      imem_we  <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (asm_clr) begin
            state   <= LEN;
            xor_acc <= 8'd0;
            idx     <= '0;
          end
        end
        LEN: begin
          if (acc) begin
            xor_acc <= xor_acc ^ rx_data;
            if (word_valid) begin
              len <= word;
              idx <= '0;
              if (word > DEPTH_W) begin
                state <= ERR;
              end else if (word == 32'd0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (acc) begin
            xor_acc <= xor_acc ^ rx_data;
            if (word_valid) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_to_addr(32'(idx));
              imem_wdata <= word;
              idx        <= idx + IDX_ONE;
              if (32'(idx) == len - 32'd1) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (acc) begin
            state <= (rx_data == xor_acc) ? DONE : ERR;
          end
        end
        default: state <= IDLE;
      endcase
      // timeout only fires in a cycle with no accepted byte, so it never races a transition above
      if (timeout_hit) begin
        state <= ERR;
      end
    end
  end

endmodule
